// File: rtl/l1_clreq_pkg.sv
// Shared constants and stream-id mapping helpers for the L1 refill request scheduler.
// Streams are statically partitioned: stream sid belongs to channel sid/sps with local id sid%sps.
package l1_clreq_pkg;

    localparam int NSTRMS_DEF   = 64;
    localparam int CHANNELS_DEF = 4;
    localparam int OUTST_DEF    = 4;

    function automatic int sid2chan(input int sid, input int sps);
        return sid / sps;
    endfunction

    function automatic int sid2lsid(input int sid, input int sps);
        return sid % sps;
    endfunction

    function automatic int mk_sid(input int chan, input int lsid, input int sps);
        return chan * sps + lsid;
    endfunction

endpackage

// File: rtl/l1_clreq_chan.sv
// One scheduler channel: round-robin arbiter, registered tile request, in-order tag FIFO
// and credit counter. Optional orphan-response detection with L1_CLREQ_SCHED_ERRCHK_EN.
module l1_clreq_chan
    import l1_clreq_pkg::*;
#(
    parameter int SPS    = 16,
    parameter int LSID_W = 4,
    parameter int OUTST  = 4,
    parameter int CNT_W  = 3
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [SPS-1:0]    i_req_v,
    output logic [SPS-1:0]    o_req_r,
    output logic [SPS-1:0]    o_rsp_v,
    input  logic [SPS-1:0]    i_rsp_r,
    output logic              o_tile_req_v,
    input  logic              i_tile_req_r,
    output logic [LSID_W-1:0] o_tile_req_lsid,
    input  logic              i_tile_rsp_v,
    output logic              o_tile_rsp_r
`ifdef L1_CLREQ_SCHED_ERRCHK_EN
    ,
    output logic              o_err
`endif
);

    localparam int AW    = $clog2(OUTST);
    localparam int PTR_W = AW + 1;

    logic [LSID_W-1:0] r_rr;
    logic              r_v;
    logic [LSID_W-1:0] r_lsid;
    logic [LSID_W-1:0] r_tag [OUTST];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_found;
    logic [LSID_W-1:0] w_gnt;
    logic              w_can_load;
    logic              w_can_acc;
    logic              w_acc;
    logic              w_empty;
    logic [LSID_W-1:0] w_head;
    logic              w_pop;

    // Local id a+k, wrapping at SPS (SPS need not be a power of two).
    function automatic logic [LSID_W-1:0] lsidAdd(input logic [LSID_W-1:0] a, input int k);
        int t;
        t = int'(a) + k;
        if (t >= SPS) t = t - SPS;
        return LSID_W'(t);
    endfunction

    assign w_can_load = !r_v || i_tile_req_r;
    assign w_can_acc  = w_can_load && (r_cnt < CNT_W'(OUTST));
    assign w_acc      = w_can_acc && w_found;
    assign w_empty    = (r_wp == r_rp);
    assign w_head     = r_tag[r_rp[AW-1:0]];
    assign w_pop      = i_tile_rsp_v && !w_empty && i_rsp_r[w_head];

    assign o_tile_req_v    = r_v;
    assign o_tile_req_lsid = r_lsid;

    // Round-robin search starting at rr for the first requesting local stream.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < SPS; k++) begin
            if (!w_found && i_req_v[lsidAdd(r_rr, k)]) begin
                w_found = 1'b1;
                w_gnt   = lsidAdd(r_rr, k);
            end
        end
    end

    // Only the granted stream sees ready, and only when a credit and the output slot are free.
    always_comb begin
        o_req_r = '0;
        if (w_acc) o_req_r[w_gnt] = 1'b1;
    end

    // Route the tile response to the stream at the FIFO head; valid never looks at ready.
    always_comb begin
        o_rsp_v = '0;
        if (i_tile_rsp_v && !w_empty) o_rsp_v[w_head] = 1'b1;
    end

    // Tile response ready: follow the owning stream, or swallow orphans when checking is on.
    always_comb begin
`ifdef L1_CLREQ_SCHED_ERRCHK_EN
        o_tile_rsp_r = w_empty ? i_tile_rsp_v : i_rsp_r[w_head];
`else
        o_tile_rsp_r = !w_empty && i_rsp_r[w_head];
`endif
    end

    // Output register and round-robin pointer; the slot empties on handshake without refill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v    <= 1'b0;
            r_lsid <= '0;
            r_rr   <= '0;
        end else if (w_acc) begin
            r_v    <= 1'b1;
            r_lsid <= w_gnt;
            r_rr   <= lsidAdd(w_gnt, 1);
        end else if (i_tile_req_r) begin
            r_v    <= 1'b0;
            r_lsid <= '0;
        end
    end

    // Tag storage holds issuing lsids in order; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (w_acc) r_tag[r_wp[AW-1:0]] <= w_gnt;
    end

    // FIFO pointers carry an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_acc) r_wp <= r_wp + PTR_W'(1);
            if (w_pop) r_rp <= r_rp + PTR_W'(1);
        end
    end

    // Credit counter: accept adds, response handshake removes, both together cancel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef L1_CLREQ_SCHED_ERRCHK_EN
    logic r_err;

    // Sticky flag for a tile response arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!reset) r_err <= 1'b0;
        else if (i_tile_rsp_v && w_empty) r_err <= 1'b1;
    end

    assign o_err = r_err;
`endif

endmodule

// File: rtl/l1_clreq_sched.sv
// L1 cache-line refill request scheduler: maps per-stream L2 ports onto per-channel tile ports.
// Optional feature macro: L1_CLREQ_SCHED_ERRCHK_EN adds o_err and consumes orphan responses.
module l1_clreq_sched
    import l1_clreq_pkg::*;
#(
    parameter int nstrms     = NSTRMS_DEF,
    parameter int channels   = CHANNELS_DEF,
    parameter int sps        = nstrms / channels,
    parameter int lsid_width = $clog2(sps),
    parameter int outst      = OUTST_DEF,
    parameter int cnt_width  = $clog2(outst + 1)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [nstrms-1:0]            i_req_v,
    output logic [nstrms-1:0]            i_req_r,
    output logic [nstrms-1:0]            o_rsp_v,
    input  logic [nstrms-1:0]            o_rsp_r,
    output logic [channels-1:0]          o_tile_req_v,
    input  logic [channels-1:0]          o_tile_req_r,
    output logic [channels*lsid_width-1:0] o_tile_req_lsid,
    input  logic [channels-1:0]          i_tile_rsp_v,
    output logic [channels-1:0]          i_tile_rsp_r
`ifdef L1_CLREQ_SCHED_ERRCHK_EN
    ,
    output logic [channels-1:0]          o_err
`endif
);

    for (genvar c = 0; c < channels; c++) begin : g_chan
        localparam int BASE = mk_sid(c, 0, sps);

        l1_clreq_chan #(
            .SPS    (sps),
            .LSID_W (lsid_width),
            .OUTST  (outst),
            .CNT_W  (cnt_width)
        ) u_chan (
            .clk             (clk),
            .reset           (reset),
            .i_req_v         (i_req_v[BASE +: sps]),
            .o_req_r         (i_req_r[BASE +: sps]),
            .o_rsp_v         (o_rsp_v[BASE +: sps]),
            .i_rsp_r         (o_rsp_r[BASE +: sps]),
            .o_tile_req_v    (o_tile_req_v[c]),
            .i_tile_req_r    (o_tile_req_r[c]),
            .o_tile_req_lsid (o_tile_req_lsid[c*lsid_width +: lsid_width]),
            .i_tile_rsp_v    (i_tile_rsp_v[c]),
            .o_tile_rsp_r    (i_tile_rsp_r[c])
`ifdef L1_CLREQ_SCHED_ERRCHK_EN
            ,
            .o_err           (o_err[c])
`endif
        );
    end

endmodule
